// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide,
// with divide-by-zero and signed-overflow results bypassing the iteration entirely.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            reg_we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_val
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rdIdx_q, rdIdx_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] operand_q, operand_d;
    logic [63:0] acc_q, acc_d;
    logic        negate_q, negate_d;
    logic        special_q, special_d;
    logic        regWe_q, regWe_d;
    logic [31:0] rdVal_q, rdVal_d;
    logic [4:0]  rdOut_q, rdOut_d;

    // Operand decode at accept time: signedness, magnitudes and the no-iteration cases.
    logic        rs1Signed, rs2Signed, rs1Neg, rs2Neg, inNegate;
    logic        divZero, divOvf;
    logic [31:0] mag1, mag2, specialVal;

    always_comb begin
        rs1Signed  = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        rs2Signed  = funct3[2] ? ~funct3[0] : ~funct3[1];
        rs1Neg     = rs1Signed & rs1_val[31];
        rs2Neg     = rs2Signed & rs2_val[31];
        mag1       = rs1Neg ? (~rs1_val + 32'd1) : rs1_val;
        mag2       = rs2Neg ? (~rs2_val + 32'd1) : rs2_val;
        inNegate   = (funct3[2] & funct3[1]) ? rs1Neg : (rs1Neg ^ rs2Neg);
        divZero    = funct3[2] & (rs2_val == 32'd0);
        divOvf     = funct3[2] & ~funct3[0] & (rs1_val == 32'h8000_0000) & (rs2_val == 32'hFFFF_FFFF);
        specialVal = 32'd0;
        if (divZero) begin
            specialVal = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
        end else if (divOvf) begin
            specialVal = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Multiply keeps the multiplier in the low half and shifts the product in from the top;
    // divide keeps the partial remainder in the high half and shifts quotient bits in from the bottom.
    logic [32:0] mulSum;
    logic [63:0] mulStep, divStep, product;
    logic        divGe;
    logic [31:0] divDiff, quotient, remainder, finResult;

    always_comb begin
        mulSum    = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? operand_q : 32'd0};
        mulStep   = {mulSum, acc_q[31:1]};
        divGe     = acc_q[63:31] >= {1'b0, operand_q};
        divDiff   = acc_q[62:31] - operand_q;
        divStep   = divGe ? {divDiff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        product   = negate_q ? (~acc_q + 64'd1) : acc_q;
        quotient  = negate_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        remainder = negate_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (special_q) begin
            finResult = acc_q[31:0];
        end else if (op_q[2]) begin
            finResult = op_q[1] ? remainder : quotient;
        end else begin
            finResult = (op_q[1:0] == 2'b00) ? product[31:0] : product[63:32];
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rdIdx_d   = rdIdx_q;
        count_d   = count_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        negate_d  = negate_q;
        special_d = special_q;
        regWe_d   = 1'b0;
        rdVal_d   = rdVal_q;
        rdOut_d   = rdOut_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d      = funct3;
                    rdIdx_d   = rd_in;
                    count_d   = 5'd0;
                    negate_d  = inNegate;
                    special_d = divZero | divOvf;
                    if (divZero || divOvf) begin
                        acc_d     = {32'd0, specialVal};
                        operand_d = 32'd0;
                        state_d   = S_FIN;
                    end else if (funct3[2]) begin
                        acc_d     = {32'd0, mag1};
                        operand_d = mag2;
                        state_d   = S_DIV;
                    end else begin
                        acc_d     = {32'd0, mag2};
                        operand_d = mag1;
                        state_d   = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d   = mulStep;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = S_FIN;
            end
            S_DIV: begin
                acc_d   = divStep;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = S_FIN;
            end
            S_FIN: begin
                regWe_d = 1'b1;
                rdVal_d = finResult;
                rdOut_d = rdIdx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            regWe_d = 1'b0;
            rdVal_d = rdVal_q;
            rdOut_d = rdOut_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            rdIdx_q   <= 5'd0;
            count_q   <= 5'd0;
            operand_q <= 32'd0;
            acc_q     <= 64'd0;
            negate_q  <= 1'b0;
            special_q <= 1'b0;
            regWe_q   <= 1'b0;
            rdVal_q   <= 32'd0;
            rdOut_q   <= 5'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rdIdx_q   <= rdIdx_d;
            count_q   <= count_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            negate_q  <= negate_d;
            special_q <= special_d;
            regWe_q   <= regWe_d;
            rdVal_q   <= rdVal_d;
            rdOut_q   <= rdOut_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign reg_we = regWe_q;
    assign rd     = rdOut_q;
    assign rd_val = rdVal_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. Sits between the register bank read ports and its write port. It takes `rs1_val`/`rs2_val` and the destination index on a start strobe. It returns `rd_val` with `reg_we` and `rd` after a fixed multi-cycle latency. The core stalls on `busy`.

## Interface

Parameters:
- `XLEN`, default 32. Operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request. Accepted only when `busy`=0.
- `flush`  in  1  — synchronous cancel of the in-flight operation.
- `funct3`  in  3  — 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  32  — dividend / multiplicand.
- `rs2_val`  in  32  — divisor / multiplier.
- `rd_in`  in  5  — destination register index.
- `busy`  out  1  — operation in flight (state ≠ IDLE).
- `reg_we`  out  1  — one-cycle write strobe to the register bank.
- `rd`  out  5  — destination index, valid with `reg_we`.
- `rd_val`  out  32  — result, valid with `reg_we`. Held until the next result.

## Operation

- FSM states: IDLE, MUL, DIV, FIN.
- In IDLE with `start`=1 and `flush`=0: latch `funct3`, `rs1_val`, `rs2_val`, `rd_in`. Later input changes are ignored.
  - Multiply codes → MUL.
  - Divide codes → DIV.
  - Special cases → FIN with the result preloaded.
- MUL: convert operands to magnitudes according to signedness.
  - MUL and MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - 32 shift-add iterations build a 64-bit unsigned product, then → FIN.
- DIV: restoring division on magnitudes (DIV/REM signed; DIVU/REMU unsigned), 32 iterations, then → FIN.
- FIN: apply sign fixup, register the result, pulse `reg_we`, → IDLE.
  - Product: negated if the operand signs differ.
  - Quotient: truncates toward zero.
  - Remainder: takes the sign of the dividend.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Special cases (no iteration):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- `start` while `busy`=1 is ignored. No queuing.
- `flush`=1 in any state → IDLE at the next edge. No `reg_we`, and `rd_val` is unchanged. `flush` wins over a simultaneous `start`.
- `rd_in`=0 completes normally with `reg_we`=1. The bank ignores writes to x0 on read.

## Timing

- Accept edge E0 (start sampled in IDLE). `busy`=1 from after E0.
- Normal ops:
  - Iterations on E1..E32.
  - FIN at E33: `reg_we`=1 and `rd_val`/`rd` valid for exactly the cycle after E33.
  - `busy`=0 in that same cycle.
  - Latency: 33 cycles from accept to write.
- Special cases: FIN at E1; `reg_we` in the cycle after E1. Latency: 1 cycle.
- Back-to-back: a new `start` is accepted in the same cycle `reg_we` is high.
- Reset (async, any time, including mid-operation): state IDLE; `busy`=0, `reg_we`=0, `rd`=0, `rd_val`=0, all internal accumulators 0.
- Release of `rst` takes effect at the next `clk` edge. The first `start` is accepted at the first edge after release.
- Result width: all arithmetic is internally 64-bit (product) and 33-bit (partial remainder). No truncation before FIN.

## Test plan

- MUL: 7 × 0xFFFFFFFD (−3) → `rd_val`=0xFFFFFFEB. `reg_we` pulses exactly 33 cycles after accept, for 1 cycle, with `rd`=`rd_in`.
- High multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Divide/remainder:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
  - REMU 10/3 → 1.
- Special cases, each with `reg_we` 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Control:
  - `start` with new operands at cycle 5 of a busy MUL → ignored; the original result is written.
  - `flush` at cycle 10 → no `reg_we`, `busy`=0 next cycle.
  - `flush`+`start` in the same IDLE cycle → not accepted.
- Reset:
  - Assert `rst` mid-DIV between edges → all outputs 0 immediately, no `reg_we`.
  - After release, DIVU 100/7 → 14 with normal latency.
